shared_dmem_responder: RTL
==========================

// Module: shared_dmem_responder
// PURPOSE
//  Memory-side responder for the cores' data-memory port. It accepts read/write requests from NUM_CORES cores
//  (core drives address, write data and Mem_Ctrl as write-enable). One round-robin winner is serviced at a time
//  against a single-port synchronous RAM. Returns read data and a one-cycle ack to the requesting core.
//  Sits between the core array and the shared data RAM in the multicore top level.
// PARAMETERS
//  NUM_CORES  4   number of requesting cores (2..8)
//  AW         8   address width (matches core DAddress)
//  DW         8   data width (matches core Ddin/ADDRo)
// PORTS
//  CLK         in   1          system clock, all state on rising edge
//  RSTn        in   1          synchronous reset, active low
//  core_req    in   NUM_CORES  request per core; held high until its ack
//  core_we     in   NUM_CORES  1=write, 0=read (core Mem_Ctrl)
//  core_addr   in   NUM_CORES*AW  packed addresses, core i at [i*AW +: AW]
//  core_wdata  in   NUM_CORES*DW  packed write data
//  core_rdata  out  NUM_CORES*DW  per-core registered read data (to core Ddin)
//  core_ack    out  NUM_CORES  one-cycle completion pulse per core
//  ram_en      out  1          RAM access strobe
//  ram_we      out  1          RAM write enable (valid with ram_en)
//  ram_addr    out  AW         RAM address
//  ram_wdata   out  DW         RAM write data
//  ram_rdata   in   DW         RAM read data, valid the cycle after ram_en&!ram_we
//  busy        out  1          high in any state other than IDLE
//  grant_id    out  3          index of the core being serviced (valid while busy)
// BEHAVIOUR
//  Reset (RSTn=0 at edge): state=IDLE; core_ack=0; core_rdata all 0; ram_en=ram_we=0; ram_addr/ram_wdata=0.
//   Also busy=0, grant_id=0, rr pointer=NUM_CORES-1 (core 0 has first priority).
//  FSM: IDLE -> ISSUE -> (write) RESP | (read) WAIT -> RESP -> IDLE.
//   IDLE : if |core_req, winner = first requesting core scanning ptr+1, ptr+2, .. modulo NUM_CORES.
//          Latch winner's addr/wdata/we and grant_id; go ISSUE. No request: stay IDLE.
//   ISSUE: ram_en=1, ram_we=latched we, ram_addr/ram_wdata=latched values (registered outputs, this cycle only).
//          we=1 -> RESP; we=0 -> WAIT.
//   WAIT : capture ram_rdata into core_rdata[grant_id]; -> RESP.
//   RESP : core_ack[grant_id]=1 for exactly this cycle; ptr<=grant_id; -> IDLE.
//  Latency from req sampled in IDLE: write ack in 2nd cycle after, read ack in 3rd; throughput 1 access / 3-4 cycles.
//  core_rdata[i] holds its value until the next read completion for core i; writes never alter it.
//  Handshake: core must keep req/we/addr/wdata stable until ack. It drops req in the cycle after ack.
//   IDLE re-arbitrates next cycle, so a core is never double-serviced.
//  req dropped mid-transaction: the access still completes and ack is still pulsed (no abort).
//  Changes to non-winning cores' requests during a transaction are ignored until the next IDLE.
//  Simultaneous requests: strict round-robin fairness; with all cores requesting continuously, grants go
//   0,1,2,3,0...
//  Reset mid-operation: FSM to IDLE immediately and no ack is issued. A write already strobed in ISSUE stays in RAM.
//  At most one bit of core_ack high in any cycle; ram_en never high outside ISSUE.
// STRUCTURE
//  Shared include mem_define.v: state encodings (S_IDLE,S_ISSUE,S_WAIT,S_RESP), default NUM_CORES/AW/DW.
//  Sub-module rr_arbiter: combinational rotating-priority select (req vector, ptr) -> winner index + valid.
//  FSM, latches and per-core rdata registers stay in this module.
// TESTING
//  1 Reset: RSTn=0 2 cycles with random req -> all core_ack=0, ram_en=0, busy=0, core_rdata=0.
//  2 Single write: core1 writes 0xA5 @0x10 -> ram_en=ram_we=1, addr 0x10, data 0xA5 one cycle later, ack[1] at +2.
//  3 Single read: core2 reads @0x10 after test 2 -> ram_en=1, ram_we=0, then ack[2] at +3 with core_rdata[2]=0xA5.
//  4 Contention: cores 0-3 all req reads together, held -> grant order 0,1,2,3, four acks, never two in one cycle.
//  5 Fairness: core0 re-requests immediately after each ack while core3 waits -> core3 served before core0's 2nd grant.
//  6 Reset mid-read: RSTn=0 in WAIT -> no ack; core_rdata cleared; next request serviced normally from IDLE.

Source files
------------

// File: rtl/shared_dmem_responder_pkg.sv
// Shared types, defaults and the rotating-index helper for the data-memory responder.
package shared_dmem_responder_pkg;
  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_AW        = 8;
  localparam int DEF_DW        = 8;
  localparam int GW            = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // base < n and step <= n, so a single wrap is enough.
  function automatic int rr_offset(input int base, input int step, input int n);
    int s;
    s = base + step;
    if (s >= n) s = s - n;
    return s;
  endfunction
endpackage

// File: rtl/shared_dmem_responder_rr_arbiter.sv
// Combinational rotating-priority select: first requester after ptr, scanning upward modulo NUM_CORES.
module shared_dmem_responder_rr_arbiter
  import shared_dmem_responder_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [GW-1:0]        ptr,
  output logic [GW-1:0]        winner,
  output logic                 valid
);

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int step = NUM_CORES; step >= 1; step--) begin
      for (int j = 0; j < NUM_CORES; j++) begin
        if (j == rr_offset(int'(ptr), step, NUM_CORES) && req[j]) begin
          winner = GW'(j);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shared_dmem_responder.sv
// Round-robin responder: serves one core at a time against a single-port synchronous RAM,
// returning registered read data and a one-cycle ack to the granted core.
module shared_dmem_responder
  import shared_dmem_responder_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic [NUM_CORES-1:0]    core_req,
  input  logic [NUM_CORES-1:0]    core_we,
  input  logic [NUM_CORES*AW-1:0] core_addr,
  input  logic [NUM_CORES*DW-1:0] core_wdata,
  output logic [NUM_CORES*DW-1:0] core_rdata,
  output logic [NUM_CORES-1:0]    core_ack,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [AW-1:0]           ram_addr,
  output logic [DW-1:0]           ram_wdata,
  input  logic [DW-1:0]           ram_rdata,
  output logic                    busy,
  output logic [GW-1:0]           grant_id
);

  state_t         state, state_nxt;
  logic [GW-1:0]  ptr, grant;
  logic           lat_we;
  logic [AW-1:0]  lat_addr;
  logic [DW-1:0]  lat_wdata;
  logic [GW-1:0]  arb_win;
  logic           arb_vld;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;

  shared_dmem_responder_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .req    (core_req),
    .ptr    (ptr),
    .winner (arb_win),
    .valid  (arb_vld)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (arb_win == GW'(j)) begin
        sel_we    = core_we[j];
        sel_addr  = core_addr[j*AW +: AW];
        sel_wdata = core_wdata[j*DW +: DW];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arb_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = lat_we ? S_RESP : S_WAIT;
      S_WAIT:  state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Requests are only looked at in IDLE; the latched copy drives the whole transaction.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      ptr        <= GW'(NUM_CORES - 1);
      grant      <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      core_rdata <= '0;
    end else begin
      if (state == S_IDLE && arb_vld) begin
        grant     <= arb_win;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end
      if (state == S_WAIT) begin
        for (int j = 0; j < NUM_CORES; j++) begin
          if (grant == GW'(j)) core_rdata[j*DW +: DW] <= ram_rdata;
        end
      end
      if (state == S_RESP) ptr <= grant;
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    ram_en   = (state == S_ISSUE);
    ram_we   = (state == S_ISSUE) && lat_we;
    core_ack = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      core_ack[j] = (state == S_RESP) && (grant == GW'(j));
    end
  end

  assign grant_id  = grant;
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;

endmodule
